arb_req_ctrl: RTL and testbench

- Request front-end for the 3-way shared-resource arbiter; sits directly upstream of it.
- Each of three devices hands over a job (valid/ready handshake plus a hold length). The block drives that device's request line r[i] and watches grant g[i].
- Holds the resource for exactly the requested number of granted cycles, then releases it.
- Enforces a release gap, waiting for g[i] to drop before taking a new job, so the arbiter always returns to its idle state between owners.

---
 rtl/arb_req_ctrl.sv | 148 ++++++++++++++
 tb/tb_arb_req_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_ctrl.sv
// Request front-end for the 3-way shared-resource arbiter: one IDLE/REQ/OWN/REL FSM per channel.
// Optional grant-wait timeout is enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_req_ctrl #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [2:0]         job_valid,
    input  logic [3*LEN_W-1:0] job_len,
    output logic [2:0]         job_ready,
    input  logic [2:0]         g,
    output logic [2:0]         r,
    output logic [2:0]         done,
    output logic               busy,
`ifdef ARB_REQ_TIMEOUT_EN
    output logic [2:0]         timeout,
`endif
    output logic [5:0]         dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_OWN  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    // Wait counter only has to hold values up to TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("arb_req_ctrl: TIMEOUT must be >= 1");
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [1:0]       state;
        logic [1:0]       state_nx;
        logic [LEN_W-1:0] len_q;
        logic [LEN_W-1:0] len_nx;
        logic [LEN_W-1:0] cnt_q;
        logic [LEN_W-1:0] cnt_nx;
        logic [LEN_W-1:0] job_l;
        logic             r_q;
        logic             done_q;
        logic             done_nx;
`ifdef ARB_REQ_TIMEOUT_EN
        logic [WAIT_W-1:0] wcnt_q;
        logic [WAIT_W-1:0] wcnt_nx;
        logic              to_q;
        logic              to_nx;
`endif

        assign job_l = job_len[i*LEN_W +: LEN_W];

        always_comb begin
            state_nx = state;
            len_nx   = len_q;
            cnt_nx   = cnt_q;
            done_nx  = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
            wcnt_nx  = wcnt_q;
            to_nx    = 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (job_valid[i]) begin
                        // A zero-length job still takes one granted cycle.
                        len_nx   = (job_l == '0) ? LEN_W'(1) : job_l;
                        state_nx = ST_REQ;
`ifdef ARB_REQ_TIMEOUT_EN
                        wcnt_nx  = '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (g[i]) begin
                        if (len_q == LEN_W'(1)) begin
                            state_nx = ST_REL;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = ST_OWN;
                            cnt_nx   = len_q - LEN_W'(1);
                        end
                    end
`ifdef ARB_REQ_TIMEOUT_EN
                    else if (wcnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_nx = ST_REL;
                        to_nx    = 1'b1;
                    end else begin
                        wcnt_nx = wcnt_q + WAIT_W'(1);
                    end
`endif
                end
                ST_OWN: begin
                    // Losing the grant mid-hold still ends the job with a done pulse.
                    if (!g[i] || cnt_q == LEN_W'(1)) begin
                        state_nx = ST_REL;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt_q - LEN_W'(1);
                    end
                end
                ST_REL: begin
                    if (!g[i]) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state  <= ST_IDLE;
                len_q  <= '0;
                cnt_q  <= '0;
                r_q    <= 1'b0;
                done_q <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
                wcnt_q <= '0;
                to_q   <= 1'b0;
`endif
            end else begin
                state  <= state_nx;
                len_q  <= len_nx;
                cnt_q  <= cnt_nx;
                r_q    <= (state_nx == ST_REQ) || (state_nx == ST_OWN);
                done_q <= done_nx;
`ifdef ARB_REQ_TIMEOUT_EN
                wcnt_q <= wcnt_nx;
                to_q   <= to_nx;
`endif
            end
        end

        assign r[i]               = r_q;
        assign done[i]            = done_q;
        assign job_ready[i]       = (state == ST_IDLE);
        assign dbg_state[2*i +: 2] = state;
`ifdef ARB_REQ_TIMEOUT_EN
        assign timeout[i]         = to_q;
`endif
    end

    assign busy = ~&job_ready;

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Bench for arb_req_ctrl: behavioural arbiter, job-level reference model with per-cycle compare,
// and directed scenarios with hand-computed trace expectations.
module tb_arb_req_ctrl;

    localparam int LEN_W = 4;
`ifdef ARB_REQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 16;
`endif

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [2:0]         job_valid = 3'b000;
    logic [3*LEN_W-1:0] job_len = '0;
    logic [2:0]         job_ready;
    logic [2:0]         g = 3'b000;
    logic [2:0]         r;
    logic [2:0]         done;
    logic               busy;
    logic [5:0]         dbg_state;
`ifdef ARB_REQ_TIMEOUT_EN
    logic [2:0]         timeout;
`endif

    int n_vec = 0;
    int n_mis = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    arb_req_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .g         (g),
        .r         (r),
        .done      (done),
        .busy      (busy),
`ifdef ARB_REQ_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .dbg_state (dbg_state)
    );

    // Registered fixed-priority arbiter that idles for a cycle between owners.
    always @(posedge clk) begin
        if (g == 3'b000) begin
            if (r[0])      g <= 3'b001;
            else if (r[1]) g <= 3'b010;
            else if (r[2]) g <= 3'b100;
        end else if ((g & r) == 3'b000) begin
            g <= 3'b000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job owns the resource for L granted cycles, then waits for the grant to drop.
    int         m_len [3];
    int         m_held[3];
    int         m_wait[3];
    bit         m_busy[3];
    bit         m_req [3];
    logic [2:0] m_to = 3'b000;
    logic [2:0] exp_q[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 0; m_req[i] = 0; m_held[i] = 0; m_wait[i] = 0; m_len[i] = 1;
            end
            m_to = 3'b000;
            exp_q.delete();
            exp_q.push_back(3'b000);
        end else begin
            logic [2:0] nd;
            logic [2:0] nt;
            nd = 3'b000;
            nt = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (!m_busy[i]) begin
                    if (job_valid[i]) begin
                        m_busy[i] = 1; m_req[i] = 1; m_held[i] = 0; m_wait[i] = 0;
                        m_len[i] = int'(job_len[i*LEN_W +: LEN_W]);
                        if (m_len[i] == 0) m_len[i] = 1;
                    end
                end else if (m_req[i]) begin
                    if (g[i]) begin
                        m_held[i]++;
                        if (m_held[i] >= m_len[i]) begin
                            m_req[i] = 0; nd[i] = 1'b1;
                        end
                    end else if (m_held[i] > 0) begin
                        m_req[i] = 0; nd[i] = 1'b1;
                    end else begin
                        m_wait[i]++;
`ifdef ARB_REQ_TIMEOUT_EN
                        if (m_wait[i] >= TB_TIMEOUT) begin
                            m_req[i] = 0; nt[i] = 1'b1;
                        end
`endif
                    end
                end else if (!g[i]) begin
                    m_busy[i] = 0;
                end
            end
            m_to = nt;
            exp_q.push_back(nd);
        end
    end

    // Trace of the current scenario, used by the hand-computed checks.
    logic [2:0] tr_r[$];
    logic [2:0] tr_g[$];
    logic [2:0] tr_d[$];
    logic [2:0] tr_jr[$];
    logic [2:0] tr_to[$];
    bit tracing = 1'b0;

    always @(negedge clk) begin
        if (run_cmp) begin
            logic [2:0] er;
            logic [2:0] ejr;
            logic [2:0] ed;
            for (int i = 0; i < 3; i++) begin
                er[i]  = m_req[i];
                ejr[i] = !m_busy[i];
            end
            chk("r", r, er);
            chk("job_ready", job_ready, ejr);
            chk("busy", busy, |ejr ? ~&ejr : 1'b1);
            if (exp_q.size() == 0) begin
                chk("done_queue_empty", 1, 0);
            end else begin
                ed = exp_q.pop_front();
                chk("done", done, ed);
            end
`ifdef ARB_REQ_TIMEOUT_EN
            chk("timeout", timeout, m_to);
`endif
        end
        if (tracing) begin
            tr_r.push_back(r);
            tr_g.push_back(g);
            tr_d.push_back(done);
            tr_jr.push_back(job_ready);
`ifdef ARB_REQ_TIMEOUT_EN
            tr_to.push_back(timeout);
`else
            tr_to.push_back(3'b000);
`endif
        end
    end

    function automatic logic [2:0] get(input int kind, input int k);
        if (k < 0 || k >= tr_r.size()) return 3'b000;
        case (kind)
            0: return tr_r[k];
            1: return tr_g[k];
            2: return tr_r[k] & tr_g[k];
            3: return tr_d[k];
            4: return tr_jr[k];
            5: return tr_jr[k] & tr_g[k];
            6: return tr_to[k];
            default: return 3'b000;
        endcase
    endfunction

    function automatic int count_hi(input int kind, input int b);
        int n;
        logic [2:0] v;
        n = 0;
        for (int k = 0; k < tr_r.size(); k++) begin
            v = get(kind, k);
            if (v[b]) n++;
        end
        return n;
    endfunction

    function automatic int find_edge(input int kind, input int b, input bit rising, input int from);
        logic [2:0] cur;
        logic [2:0] prv;
        for (int k = (from < 1 ? 1 : from); k < tr_r.size(); k++) begin
            cur = get(kind, k);
            prv = get(kind, k - 1);
            if (rising && cur[b] && !prv[b]) return k;
            if (!rising && !cur[b] && prv[b]) return k;
        end
        return -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_trace;
        tr_r.delete(); tr_g.delete(); tr_d.delete(); tr_jr.delete(); tr_to.delete();
        tracing = 1'b1;
    endtask

    // Offer a job set for one cycle and trace the following cycles.
    task automatic run_job(input logic [2:0] mask, input int l0, input int l1, input int l2,
                           input int hold, input int cycles);
        job_len   = {LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
        job_valid = mask;
        start_trace();
        step(hold);
        job_valid = 3'b000;
        step(cycles);
        tracing = 1'b0;
    endtask

    int         fall;
    int         rise;
    logic [2:0] v;
    int         tbl[4][4] = '{'{5, 5, 0, 15}, '{3, 1, 4, 0}, '{6, 0, 15, 2}, '{7, 3, 1, 2}};
    int         tbl_ov[4][3] = '{'{5, 0, 15}, '{1, 4, 0}, '{0, 15, 2}, '{3, 1, 2}};

    initial begin
        step(2);
        chk("rst_r", r, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_ready", job_ready, 3'b111);
        chk("rst_busy", busy, 1'b0);
        resetn  = 1'b1;
        run_cmp = 1'b1;
        step(2);

        // Single ch0 job, L=3.
        run_job(3'b001, 3, 0, 0, 1, 11);
        chk("t1_r_cycles", count_hi(0, 0), 4);
        chk("t1_overlap", count_hi(2, 0), 3);
        chk("t1_g_cycles", count_hi(1, 0), 4);
        chk("t1_done_pulses", count_hi(3, 0), 1);
        fall = find_edge(0, 0, 0, 1);
        chk("t1_r_fall_idx", fall, 5);
        v = get(3, fall);
        chk("t1_done_at_fall", v[0], 1'b1);
        chk("t1_ready_gap", find_edge(4, 0, 1, fall) - fall, 2);

        // L=0 on ch1 behaves as L=1.
        run_job(3'b010, 0, 0, 0, 1, 8);
        chk("t2_overlap", count_hi(2, 1), 1);
        chk("t2_r_cycles", count_hi(0, 1), 2);
        chk("t2_done_pulses", count_hi(3, 1), 1);

`ifndef ARB_REQ_TIMEOUT_EN
        // Three-way contention.
        run_job(3'b111, 2, 2, 1, 1, 30);
        v = get(0, 1);
        chk("t3_r_all", v, 3'b111);
        chk("t3_grant0_idx", find_edge(1, 0, 1, 1), 2);
        chk("t3_grant1_idx", find_edge(1, 1, 1, 1), 6);
        chk("t3_grant2_idx", find_edge(1, 2, 1, 1), 10);
        for (int i = 0; i < 3; i++) begin
            chk("t3_done_pulses", count_hi(3, i), 1);
            chk("t3_overlap", count_hi(2, i), (i == 2) ? 1 : 2);
        end
`endif

        // Back-to-back on ch2: offer held through the release phase.
        run_job(3'b100, 0, 0, 1, 6, 8);
        fall = find_edge(0, 2, 0, 1);
        rise = find_edge(0, 2, 1, fall);
        chk("t4_first_fall", fall, 3);
        chk("t4_rerequest_gap", rise - fall, 3);
        v = get(4, 4);
        chk("t4_ready_in_rel", v[2], 1'b0);
        chk("t4_ready_while_granted", count_hi(5, 2), 0);
        chk("t4_done_pulses", count_hi(3, 2), 2);

        // Reset while ch0 is mid-hold (L=7, two granted cycles in).
        job_len   = {LEN_W'(0), LEN_W'(0), LEN_W'(7)};
        job_valid = 3'b001;
        step(1);
        job_valid = 3'b000;
        step(3);
        resetn = 1'b0;
        #1;
        chk("t5_rst_r", r, 3'b000);
        chk("t5_rst_done", done, 3'b000);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ready", job_ready, 3'b111);
        #1;
        resetn = 1'b1;
        start_trace();
        step(8);
        tracing = 1'b0;
        chk("t5_no_done_after", count_hi(3, 0), 0);
        chk("t5_no_request_after", count_hi(0, 0), 0);

`ifndef ARB_REQ_TIMEOUT_EN
        // Directed mixes, including the longest hold length.
        for (int t = 0; t < 4; t++) begin
            run_job(3'(tbl[t][0]), tbl[t][1], tbl[t][2], tbl[t][3], 1, 45);
            for (int i = 0; i < 3; i++) begin
                chk("t6_overlap", count_hi(2, i), tbl_ov[t][i]);
            end
        end
`else
        // Ch1 starved by a long ch0 hold times out.
        run_job(3'b011, 10, 2, 0, 1, 25);
        chk("t7_r1_cycles", count_hi(0, 1), 4);
        chk("t7_timeout_pulses", count_hi(6, 1), 1);
        chk("t7_done1_pulses", count_hi(3, 1), 0);
        chk("t7_overlap0", count_hi(2, 0), 10);
        chk("t7_done0_pulses", count_hi(3, 0), 1);
`endif

        step(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
